btn_event_fsm: RTL and testbench
================================

BTN_EVENT_FSM -- requirements
Module: btn_event_fsm

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 8: qualifying ticks before a press is accepted (~10.5 ms at a 1.31 ms tick); legal range >= 2.
REQ-002 SHALL have parameter LONG_TICKS, default 400: total ticks from first tick to long-press (~524 ms); SHALL be > DEB_TICKS.
REQ-003 SHALL have parameter REP_TICKS, default 80: ticks between auto-repeat pulses after long-press; legal range >= 1.
REQ-004 SHALL have parameter GAP_CYCLES, default 131088 (2^17+16): consecutive tick-free cycles that signal release; legal range >= 2.
REQ-005 SHALL have port CLK_100_I, input, 1 bit: the single 100 MHz clock; all logic on rising edge.
REQ-006 SHALL have port RST_N_I, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port DBTN_I, input, 1 bit: one-cycle tick from the upstream button counter, periodic while the button is held, absent while released.
REQ-008 SHALL have port PRESS_O, output, 1 bit: one-cycle pulse on an accepted press.
REQ-009 SHALL have port SHORT_O, output, 1 bit: one-cycle pulse on release before long-press.
REQ-010 SHALL have port LONG_O, output, 1 bit: one-cycle pulse when long-press threshold is reached.
REQ-011 SHALL have port REPEAT_O, output, 1 bit: one-cycle auto-repeat pulse during long-press.
REQ-012 SHALL have port RELEASE_O, output, 1 bit: one-cycle pulse on release of an accepted press.
REQ-013 SHALL have port HELD_O, output, 1 bit: level, high while an accepted press is active.
REQ-014 SHALL have port PRESS_CNT_O, output, 8 bits: count of accepted presses.

Function
REQ-015 SHALL implement states IDLE, DEBOUNCE, HELD and LONG.
REQ-016 SHALL keep gap_cnt: cleared on any cycle with DBTN_I=1, else incremented, saturating at GAP_CYCLES.
REQ-017 SHALL define timeout as DBTN_I=0 and gap_cnt=GAP_CYCLES-1 in a non-IDLE state; tick and timeout SHALL be mutually exclusive.
REQ-018 IDLE: on tick, SHALL go to DEBOUNCE with tick_cnt=1; otherwise stay in IDLE.
REQ-019 DEBOUNCE: on tick, SHALL increment tick_cnt; the tick that makes tick_cnt=DEB_TICKS SHALL move to HELD and pulse PRESS_O.
REQ-020 DEBOUNCE: on timeout, SHALL return to IDLE with no output pulse (glitch reject).
REQ-021 HELD: on tick, SHALL increment tick_cnt; the tick that makes tick_cnt=LONG_TICKS SHALL move to LONG, pulse LONG_O and clear rep_cnt.
REQ-022 HELD: on timeout, SHALL go to IDLE and pulse SHORT_O and RELEASE_O in the same cycle.
REQ-023 LONG: on tick, SHALL increment rep_cnt; on reaching REP_TICKS it SHALL pulse REPEAT_O and clear rep_cnt.
REQ-024 LONG: on timeout, SHALL go to IDLE and pulse RELEASE_O only.
REQ-025 SHALL register all outputs; each pulse SHALL appear exactly 1 cycle after the triggering tick or timeout cycle and last 1 cycle.
REQ-026 HELD_O SHALL be high exactly while state is HELD or LONG, registered with the state.
REQ-027 PRESS_CNT_O SHALL increment in the cycle PRESS_O is high and wrap 255->0.
REQ-028 tick_cnt SHALL be $clog2(LONG_TICKS+1) bits wide and rep_cnt $clog2(REP_TICKS+1) bits wide; neither SHALL overflow.
REQ-029 SHALL clear tick_cnt on every entry to IDLE; a tick in the same cycle as the return to IDLE is impossible per REQ-017.

Reset
REQ-030 Asserting RST_N_I low SHALL immediately force IDLE and set gap_cnt, tick_cnt, rep_cnt, PRESS_CNT_O and all outputs to 0, including mid-press.
REQ-031 After RST_N_I goes high with the button still held, the next tick SHALL start a fresh DEBOUNCE; no RELEASE_O or SHORT_O pulse SHALL be emitted for the aborted press.

Verification (params DEB_TICKS=4, LONG_TICKS=20, REP_TICKS=5, GAP_CYCLES=10; ticks every 4 cycles when held)
REQ-032 3 ticks then silence -> no pulses, HELD_O=0, return to IDLE 10 cycles after last tick.
REQ-033 8 ticks then silence -> PRESS_O 1 cycle after tick 4, SHORT_O+RELEASE_O together 1 cycle after timeout, PRESS_CNT_O=1.
REQ-034 31 ticks then silence -> PRESS_O after tick 4, LONG_O after tick 20, REPEAT_O after ticks 25 and 30, RELEASE_O only (no SHORT_O) after timeout.
REQ-035 256 short presses -> PRESS_CNT_O wraps to 0.
REQ-036 RST_N_I low during LONG, released while ticks continue -> all outputs 0 asynchronously, then PRESS_O after 4 more ticks, no RELEASE_O for the aborted press.
REQ-037 Tick gap of exactly 9 cycles during HELD -> no timeout; gap of 10 cycles -> timeout.

Source files
------------

// File: rtl/btn_event_fsm.sv
// Button event decoder: turns a periodic "held" tick stream into
// press / short / long / repeat / release pulses plus a press counter.
//
// Ports:
//   CLK_100_I    100 MHz clock, rising edge
//   RST_N_I      asynchronous active-low reset
//   DBTN_I       one-cycle tick, periodic while the button is held
//   PRESS_O      pulse: press accepted after DEB_TICKS ticks
//   SHORT_O      pulse: released before the long-press threshold
//   LONG_O       pulse: LONG_TICKS ticks reached
//   REPEAT_O     pulse: every REP_TICKS ticks while in long-press
//   RELEASE_O    pulse: an accepted press was released
//   HELD_O       level: an accepted press is active
//   PRESS_CNT_O  count of accepted presses, wraps 255 -> 0
module btn_event_fsm #(
  parameter int DEB_TICKS  = 8,
  parameter int LONG_TICKS = 400,
  parameter int REP_TICKS  = 80,
  parameter int GAP_CYCLES = 131088
) (
  input  logic       CLK_100_I,
  input  logic       RST_N_I,
  input  logic       DBTN_I,
  output logic       PRESS_O,
  output logic       SHORT_O,
  output logic       LONG_O,
  output logic       REPEAT_O,
  output logic       RELEASE_O,
  output logic       HELD_O,
  output logic [7:0] PRESS_CNT_O
);

  localparam int TW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REP_TICKS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] DEB_T   = TW'(DEB_TICKS);
  localparam logic [TW-1:0] LONG_T  = TW'(LONG_TICKS);
  localparam logic [RW-1:0] REP_T   = RW'(REP_TICKS);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_TO  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_LONG
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tick_cnt;
  logic [TW-1:0]   w_tick_nxt;
  logic [TW-1:0]   w_tick_inc;
  logic [RW-1:0]   r_rep_cnt;
  logic [RW-1:0]   w_rep_nxt;
  logic [RW-1:0]   w_rep_inc;
  logic [GW-1:0]   r_gap_cnt;
  logic            w_timeout;

  logic            w_press;
  logic            w_short;
  logic            w_long;
  logic            w_repeat;
  logic            w_release;
  logic            w_held;

  logic            r_press;
  logic            r_short;
  logic            r_long;
  logic            r_repeat;
  logic            r_release;
  logic            r_held;
  logic [7:0]      r_press_cnt;

  assign w_tick_inc = r_tick_cnt + TW'(1);
  assign w_rep_inc  = r_rep_cnt + RW'(1);

  // Release is inferred from GAP_CYCLES tick-free cycles, the current
  // one included; a tick cycle can never also be a timeout cycle.
  assign w_timeout = !DBTN_I
                  && (r_gap_cnt == GAP_TO)
                  && (r_state != S_IDLE);

  always_ff @(posedge CLK_100_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_gap_cnt <= '0;
    end else if (DBTN_I) begin
      r_gap_cnt <= '0;
    end else if (r_gap_cnt != GAP_MAX) begin
      r_gap_cnt <= r_gap_cnt + GW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_press     = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        if (DBTN_I) begin
          w_state_nxt = S_DEBOUNCE;
          w_tick_nxt  = TW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (DBTN_I) begin
          w_tick_nxt = w_tick_inc;
          if (w_tick_inc == DEB_T) begin
            w_state_nxt = S_HELD;
            w_press     = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
        end
      end
      S_HELD: begin
        if (DBTN_I) begin
          w_tick_nxt = w_tick_inc;
          if (w_tick_inc == LONG_T) begin
            w_state_nxt = S_LONG;
            w_long      = 1'b1;
            w_rep_nxt   = '0;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_short     = 1'b1;
          w_release   = 1'b1;
        end
      end
      S_LONG: begin
        // tick_cnt parks at LONG_TICKS here; rep_cnt paces repeats
        if (DBTN_I) begin
          if (w_rep_inc == REP_T) begin
            w_repeat  = 1'b1;
            w_rep_nxt = '0;
          end else begin
            w_rep_nxt = w_rep_inc;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_release   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = '0;
        w_rep_nxt   = '0;
      end
    endcase
    w_held = (w_state_nxt == S_HELD)
          || (w_state_nxt == S_LONG);
  end

  always_ff @(posedge CLK_100_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_rep_cnt   <= '0;
      r_press     <= 1'b0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
      r_release   <= 1'b0;
      r_held      <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_rep_cnt   <= w_rep_nxt;
      r_press     <= w_press;
      r_short     <= w_short;
      r_long      <= w_long;
      r_repeat    <= w_repeat;
      r_release   <= w_release;
      r_held      <= w_held;
      r_press_cnt <= r_press_cnt + {7'd0, w_press};
    end
  end

  assign PRESS_O     = r_press;
  assign SHORT_O     = r_short;
  assign LONG_O      = r_long;
  assign REPEAT_O    = r_repeat;
  assign RELEASE_O   = r_release;
  assign HELD_O      = r_held;
  assign PRESS_CNT_O = r_press_cnt;

endmodule

// File: tb/tb_btn_event_fsm.sv
// Bench for btn_event_fsm: tick schedules checked cycle by cycle
// against an event-level model of the press/long/repeat/release rules.
module tb_btn_event_fsm;

  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int REP  = 5;
  localparam int GAP  = 10;
  localparam int MAXC = 4200;

  logic       clk;
  logic       rst_n;
  logic       dbtn;
  logic       press_o;
  logic       short_o;
  logic       long_o;
  logic       repeat_o;
  logic       release_o;
  logic       held_o;
  logic [7:0] cnt_o;

  int checks;
  int failures;

  logic [5:0] obs_ev  [MAXC];
  logic [7:0] obs_cnt [MAXC];
  logic [5:0] exp_ev  [MAXC];
  logic [7:0] exp_cnt [MAXC];
  logic [7:0] exp_base;

  btn_event_fsm #(
    .DEB_TICKS (DEB),
    .LONG_TICKS(LNG),
    .REP_TICKS (REP),
    .GAP_CYCLES(GAP)
  ) dut (
    .CLK_100_I  (clk),
    .RST_N_I    (rst_n),
    .DBTN_I     (dbtn),
    .PRESS_O    (press_o),
    .SHORT_O    (short_o),
    .LONG_O     (long_o),
    .REPEAT_O   (repeat_o),
    .RELEASE_O  (release_o),
    .HELD_O     (held_o),
    .PRESS_CNT_O(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event bits: 0 press, 1 short, 2 long, 3 repeat, 4 release, 5 held.
  // Ticks closer than GAP+1 cycles belong to one hold; a hold of n
  // ticks presses on tick DEB, longs on tick LNG, repeats every REP
  // ticks after that, and releases GAP+1 cycles after its last tick.
  task automatic build_model(input int tk[$], input int n);
    int i;
    int j;
    int len;
    int rc;
    int pc;
    int lc;
    for (int c = 0; c < n; c++) begin
      exp_ev[c]  = '0;
      exp_cnt[c] = exp_base;
    end
    i = 0;
    while (i < tk.size()) begin
      j = i;
      while (j + 1 < tk.size() && tk[j+1] - tk[j] <= GAP) j++;
      len = j - i + 1;
      rc  = tk[j] + GAP + 1;
      if (len >= DEB) begin
        pc = tk[i+DEB-1] + 1;
        for (int c = pc; c < n; c++) begin
          if (c < rc) exp_ev[c][5] = 1'b1;
          exp_cnt[c] = exp_cnt[c] + 8'd1;
        end
        if (pc < n) exp_ev[pc][0] = 1'b1;
        if (len >= LNG) begin
          lc = tk[i+LNG-1] + 1;
          if (lc < n) exp_ev[lc][2] = 1'b1;
          for (int k = LNG - 1 + REP; k < len; k += REP) begin
            if (tk[i+k] + 1 < n) exp_ev[tk[i+k]+1][3] = 1'b1;
          end
        end
        if (rc < n) begin
          exp_ev[rc][4] = 1'b1;
          if (len < LNG) exp_ev[rc][1] = 1'b1;
        end
      end
      i = j + 1;
    end
  endtask

  // Cycle c: outputs sampled mid-cycle, then the tick for c driven.
  task automatic run_seq(input int tk[$], input int n);
    int k;
    k = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs_ev[c]  = {held_o, release_o, repeat_o,
                    long_o, short_o, press_o};
      obs_cnt[c] = cnt_o;
      if (k < tk.size() && tk[k] == c) begin
        dbtn = 1'b1;
        k++;
      end else begin
        dbtn = 1'b0;
      end
    end
  endtask

  task automatic periodic(output int tk[$], input int first,
                          input int cnt, input int step);
    tk = {};
    for (int k = 0; k < cnt; k++) tk.push_back(first + k * step);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dbtn  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({held_o, release_o, repeat_o, long_o, short_o, press_o}
        !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b want=000000",
               {held_o, release_o, repeat_o, long_o, short_o, press_o});
    end
    checks++;
    if (cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d want=0", cnt_o);
    end
    rst_n = 1'b1;
    exp_base = 8'd0;
  endtask

  task automatic test_glitch();
    int tk[$];
    int n;
    periodic(tk, 2, 3, 4);
    n = tk[tk.size()-1] + GAP + 3;
    build_model(tk, n);
    run_seq(tk, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL glitch c=%0d ev=%b want=%b cnt=%0d want=%0d",
                 c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
      end
    end
    exp_base = exp_cnt[n-1];
  endtask

  task automatic test_short();
    int tk[$];
    int n;
    periodic(tk, 1, 8, 4);
    n = tk[tk.size()-1] + GAP + 3;
    build_model(tk, n);
    run_seq(tk, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL short c=%0d ev=%b want=%b cnt=%0d want=%0d",
                 c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
      end
    end
    checks++;
    if (obs_cnt[n-1] !== 8'd1) begin
      failures++;
      $display("FAIL short_cnt got=%0d want=1", obs_cnt[n-1]);
    end
    exp_base = exp_cnt[n-1];
  endtask

  task automatic test_long();
    int tk[$];
    int n;
    periodic(tk, 0, 31, 4);
    n = tk[tk.size()-1] + GAP + 3;
    build_model(tk, n);
    run_seq(tk, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL long c=%0d ev=%b want=%b cnt=%0d want=%0d",
                 c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
      end
    end
    exp_base = exp_cnt[n-1];
  endtask

  // Gap of 9 free cycles keeps the hold; 10 free cycles releases it.
  task automatic test_gap_boundary();
    int tk[$];
    int n;
    tk = {0, 4, 8, 12, 22, 26, 30, 41, 45, 49, 53};
    n = tk[tk.size()-1] + GAP + 3;
    build_model(tk, n);
    run_seq(tk, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL gap c=%0d ev=%b want=%b cnt=%0d want=%0d",
                 c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
      end
    end
    exp_base = exp_cnt[n-1];
  endtask

  task automatic test_random();
    int tk[$];
    int n;
    int t;
    int cnt;
    for (int r = 0; r < 10; r++) begin
      tk  = {};
      t   = $urandom_range(0, 3);
      cnt = $urandom_range(1, 40);
      for (int k = 0; k < cnt; k++) begin
        tk.push_back(t);
        if ($urandom_range(0, 7) == 0) t += $urandom_range(GAP - 1, GAP + 3);
        else t += $urandom_range(1, 6);
      end
      n = tk[tk.size()-1] + GAP + 3;
      build_model(tk, n);
      run_seq(tk, n);
      for (int c = 0; c < n; c++) begin
        checks++;
        if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
          failures++;
          $display("FAIL rand%0d c=%0d ev=%b want=%b cnt=%0d want=%0d",
                   r, c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
        end
      end
      exp_base = exp_cnt[n-1];
    end
  endtask

  task automatic test_reset_mid_long();
    int tk[$];
    int n;
    periodic(tk, 0, 23, 4);
    n = tk[tk.size()-1] + 2;
    build_model(tk, n);
    run_seq(tk, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL prelong c=%0d ev=%b want=%b cnt=%0d want=%0d",
                 c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({held_o, release_o, repeat_o, long_o, short_o, press_o, cnt_o}
        !== 14'b0) begin
      failures++;
      $display("FAIL async_rst outs=%b cnt=%0d want=0",
               {held_o, release_o, repeat_o, long_o, short_o, press_o},
               cnt_o);
    end
    @(negedge clk) dbtn = 1'b1;
    @(negedge clk) dbtn = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_base = 8'd0;
    periodic(tk, 1, 6, 4);
    n = tk[tk.size()-1] + GAP + 3;
    build_model(tk, n);
    run_seq(tk, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL postrst c=%0d ev=%b want=%b cnt=%0d want=%0d",
                 c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
      end
    end
    exp_base = exp_cnt[n-1];
  endtask

  task automatic test_wrap();
    int tk[$];
    int n;
    rst_n = 1'b0;
    dbtn  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_base = 8'd0;
    tk = {};
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < DEB; k++) tk.push_back(p * 16 + k);
    end
    n = tk[tk.size()-1] + GAP + 3;
    build_model(tk, n);
    run_seq(tk, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs_ev[c] !== exp_ev[c] || obs_cnt[c] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL wrap c=%0d ev=%b want=%b cnt=%0d want=%0d",
                 c, obs_ev[c], exp_ev[c], obs_cnt[c], exp_cnt[c]);
      end
    end
    checks++;
    if (obs_cnt[n-1] !== 8'd0) begin
      failures++;
      $display("FAIL wrap_final got=%0d want=0", obs_cnt[n-1]);
    end
    exp_base = exp_cnt[n-1];
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    dbtn     = 1'b0;
    exp_base = 8'd0;
    test_reset();
    test_glitch();
    test_short();
    test_long();
    test_gap_boundary();
    test_random();
    test_reset_mid_long();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
